// File: rtl/branch_predictor_unit_if.sv
// Shared branch/next-PC types and the fetch/execute bus of the branch predictor.
package branch_predictor_pkg;
  typedef enum logic [2:0] {NoBranch, Jump, CondBranch, Mret, Sret} branch_t;
  typedef enum logic [2:0] {Beq, Bne, Blt, Bge, Bltu, Bgeu} cond_branch_t;
  typedef enum logic [1:0] {PcPlus4, PcOrReadDataPlusImm, Mepc, Sepc} pc_src_t;
endpackage

interface branch_predictor_if #(
  parameter int Width     = 64,
  parameter int CountBits = 32
);
  // fetch-side prediction port
  logic [Width-1:0]                    pred_pc;
  logic                                pred_hit;
  logic                                pred_taken;
  logic [Width-1:0]                    pred_target;
  // execute-side resolve port
  logic                                res_valid;
  logic [Width-1:0]                    res_pc;
  branch_predictor_pkg::branch_t       branch_type;
  branch_predictor_pkg::cond_branch_t  cond_branch_type;
  logic [Width-1:0]                    read_data_1;
  logic [Width-1:0]                    read_data_2;
  logic [Width-1:0]                    res_target;
  logic                                res_pred_taken;
  logic [Width-1:0]                    res_pred_target;
  branch_predictor_pkg::pc_src_t       pc_src;
  logic                                mispredict;
  // performance counters
  logic [CountBits-1:0]                branch_count;
  logic [CountBits-1:0]                mispredict_count;

  modport master (
    output pred_pc, res_valid, res_pc, branch_type, cond_branch_type,
           read_data_1, read_data_2, res_target, res_pred_taken, res_pred_target,
    input  pred_hit, pred_taken, pred_target, pc_src, mispredict,
           branch_count, mispredict_count
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, branch_type, cond_branch_type,
           read_data_1, read_data_2, res_target, res_pred_taken, res_pred_target,
    output pred_hit, pred_taken, pred_target, pc_src, mispredict,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with saturating direction counters: same-cycle fetch
// prediction, execute-stage resolution, misprediction flag, table training
// and saturating performance counters.
module branch_predictor_unit
  import branch_predictor_pkg::*;
#(
  parameter int Width       = 64,
  parameter int Entries     = 64,
  parameter int TagBits     = 8,
  parameter int CounterBits = 2,
  parameter int CountBits   = 32
) (
  input  logic              clock,
  input  logic              reset,
  branch_predictor_if.slave bus
);

  localparam int IndexBits = $clog2(Entries);
  localparam logic [CounterBits-1:0] CtrMax    = '1;
  localparam logic [CounterBits-1:0] CtrWeakNt = CtrMax >> 1;
  localparam logic [CounterBits-1:0] CtrWeakT  = CtrMax ^ CtrWeakNt;
  localparam logic [CountBits-1:0]   CountMax  = '1;

  logic [Entries-1:0]     r_valid;
  logic [TagBits-1:0]     r_tag    [Entries];
  logic [Width-1:0]       r_target [Entries];
  logic [CounterBits-1:0] r_ctr    [Entries];
  logic [CountBits-1:0]   r_branch_count;
  logic [CountBits-1:0]   r_mispredict_count;

  logic [IndexBits-1:0]   w_pred_idx;
  logic [TagBits-1:0]     w_pred_tag;
  logic                   w_pred_hit;
  logic                   w_pred_taken;
  logic [IndexBits-1:0]   w_res_idx;
  logic [TagBits-1:0]     w_res_tag;
  logic                   w_res_hit;
  logic                   w_is_branch;
  logic                   w_is_trap;
  logic                   w_cond_taken;
  logic                   w_actual_taken;
  logic                   w_mispredict;
  logic                   w_unused;

  assign w_pred_idx   = bus.pred_pc[IndexBits+1:2];
  assign w_pred_tag   = bus.pred_pc[IndexBits+TagBits+1:IndexBits+2];
  assign w_pred_hit   = r_valid[w_pred_idx] && (r_tag[w_pred_idx] == w_pred_tag);
  assign w_pred_taken = w_pred_hit && r_ctr[w_pred_idx][CounterBits-1];

  assign bus.pred_hit    = w_pred_hit;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_taken ? r_target[w_pred_idx] : '0;

  assign w_res_idx   = bus.res_pc[IndexBits+1:2];
  assign w_res_tag   = bus.res_pc[IndexBits+TagBits+1:IndexBits+2];
  assign w_res_hit   = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
  assign w_is_branch = bus.res_valid && (bus.branch_type == Jump || bus.branch_type == CondBranch);
  assign w_is_trap   = bus.res_valid && (bus.branch_type == Mret || bus.branch_type == Sret);

  // Condition evaluation over the full operand width.
  always_comb begin
    w_cond_taken = 1'b0;
    case (bus.cond_branch_type)
      Beq:     w_cond_taken = (bus.read_data_1 == bus.read_data_2);
      Bne:     w_cond_taken = (bus.read_data_1 != bus.read_data_2);
      Blt:     w_cond_taken = ($signed(bus.read_data_1) <  $signed(bus.read_data_2));
      Bge:     w_cond_taken = ($signed(bus.read_data_1) >= $signed(bus.read_data_2));
      Bltu:    w_cond_taken = (bus.read_data_1 <  bus.read_data_2);
      Bgeu:    w_cond_taken = (bus.read_data_1 >= bus.read_data_2);
      default: w_cond_taken = 1'b0;
    endcase
  end

  assign w_actual_taken = bus.res_valid &&
                          (bus.branch_type == Jump || (bus.branch_type == CondBranch && w_cond_taken));

  // Traps are redirected by the trap path, so they never count as mispredicted.
  assign w_mispredict = bus.res_valid && !w_is_trap &&
                        ((w_actual_taken != bus.res_pred_taken) ||
                         (w_actual_taken && (bus.res_target != bus.res_pred_target)));
  assign bus.mispredict = w_mispredict;

  // Architecturally correct next-PC source for the resolving instruction.
  always_comb begin
    bus.pc_src = PcPlus4;
    if (bus.res_valid && bus.branch_type == Mret)      bus.pc_src = Mepc;
    else if (bus.res_valid && bus.branch_type == Sret) bus.pc_src = Sepc;
    else if (w_actual_taken)                           bus.pc_src = PcOrReadDataPlusImm;
  end

  // Table training: counter update and retarget on hit, allocate on taken miss,
  // drop aliasing entries hit by non-branches.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < Entries; i++) r_ctr[i] <= CtrWeakNt;
    end else if (w_is_branch) begin
      if (w_res_hit) begin
        if (w_actual_taken) begin
          if (r_ctr[w_res_idx] != CtrMax) r_ctr[w_res_idx] <= r_ctr[w_res_idx] + 1'b1;
          r_target[w_res_idx] <= bus.res_target;
        end else if (r_ctr[w_res_idx] != '0) begin
          r_ctr[w_res_idx] <= r_ctr[w_res_idx] - 1'b1;
        end
      end else if (w_actual_taken) begin
        r_valid[w_res_idx]  <= 1'b1;
        r_tag[w_res_idx]    <= w_res_tag;
        r_target[w_res_idx] <= bus.res_target;
        r_ctr[w_res_idx]    <= (bus.branch_type == Jump) ? CtrMax : CtrWeakT;
      end
    end else if (bus.res_valid && bus.branch_type == NoBranch && w_res_hit) begin
      r_valid[w_res_idx] <= 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_is_branch && r_branch_count != CountMax)
        r_branch_count <= r_branch_count + 1'b1;
      if (w_mispredict && r_mispredict_count != CountMax)
        r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;

  // Only index/tag bits of the PCs address the table.
  assign w_unused = ^{bus.pred_pc, bus.res_pc};

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Bench for branch_predictor_unit: directed scenarios plus randomized
// resolve/predict traffic checked against an array-based reference model.
module tb_branch_predictor_unit;
  import branch_predictor_pkg::*;

  localparam int Width       = 64;
  localparam int Entries     = 16;
  localparam int TagBits     = 8;
  localparam int CounterBits = 2;
  localparam int CountBits   = 4;
  localparam int CMax        = (1 << CounterBits) - 1;
  localparam int WeakT       = 1 << (CounterBits - 1);
  localparam int WeakNt      = WeakT - 1;
  localparam int CountMax    = (1 << CountBits) - 1;

  logic clock = 1'b0;
  logic rst_b = 1'b0;

  branch_predictor_if #(.Width(Width), .CountBits(CountBits)) bus ();

  branch_predictor_unit #(
    .Width(Width), .Entries(Entries), .TagBits(TagBits),
    .CounterBits(CounterBits), .CountBits(CountBits)
  ) dut (
    .clock(clock),
    .reset(rst_b),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // reference model
  bit               m_valid  [Entries];
  int               m_tag    [Entries];
  logic [Width-1:0] m_target [Entries];
  int               m_ctr    [Entries];
  int               m_bc, m_mc;
  int               n_vec, n_err;

  function automatic int idx_of(logic [Width-1:0] pc);
    return int'((pc / 4) % Entries);
  endfunction

  function automatic int tag_of(logic [Width-1:0] pc);
    return int'((pc / (4 * Entries)) % (1 << TagBits));
  endfunction

  function automatic bit m_hit(logic [Width-1:0] pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  function automatic bit m_taken(logic [Width-1:0] pc);
    return m_hit(pc) && m_ctr[idx_of(pc)] >= WeakT;
  endfunction

  function automatic logic [Width-1:0] m_tgt(logic [Width-1:0] pc);
    return m_taken(pc) ? m_target[idx_of(pc)] : '0;
  endfunction

  function automatic bit m_actual();
    logic [Width-1:0] a, b;
    a = bus.read_data_1;
    b = bus.read_data_2;
    if (!bus.res_valid) return 1'b0;
    if (bus.branch_type == Jump) return 1'b1;
    if (bus.branch_type != CondBranch) return 1'b0;
    case (bus.cond_branch_type)
      Beq:     return a == b;
      Bne:     return a != b;
      Blt:     return $signed(a) <  $signed(b);
      Bge:     return $signed(a) >= $signed(b);
      Bltu:    return a <  b;
      Bgeu:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic pc_src_t m_pc_src();
    if (bus.res_valid && bus.branch_type == Mret) return Mepc;
    if (bus.res_valid && bus.branch_type == Sret) return Sepc;
    if (m_actual()) return PcOrReadDataPlusImm;
    return PcPlus4;
  endfunction

  function automatic bit m_mis();
    bit a;
    if (!bus.res_valid || bus.branch_type == Mret || bus.branch_type == Sret) return 1'b0;
    a = m_actual();
    return (a != bus.res_pred_taken) || (a && bus.res_target != bus.res_pred_target);
  endfunction

  task automatic model_commit();
    int i;
    bit a, h, mis;
    if (!rst_b) begin
      for (int k = 0; k < Entries; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = WeakNt;
      end
      m_bc = 0;
      m_mc = 0;
      return;
    end
    if (!bus.res_valid) return;
    i   = idx_of(bus.res_pc);
    h   = m_hit(bus.res_pc);
    a   = m_actual();
    mis = m_mis();
    if (bus.branch_type == Jump || bus.branch_type == CondBranch) begin
      if (h) begin
        m_ctr[i] = a ? ((m_ctr[i] < CMax) ? m_ctr[i] + 1 : CMax)
                     : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (a) m_target[i] = bus.res_target;
      end else if (a) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(bus.res_pc);
        m_target[i] = bus.res_target;
        m_ctr[i]    = (bus.branch_type == Jump) ? CMax : WeakT;
      end
      if (m_bc < CountMax) m_bc++;
    end else if (bus.branch_type == NoBranch && h) begin
      m_valid[i] = 1'b0;
    end
    if (mis && m_mc < CountMax) m_mc++;
  endtask

  task automatic step();
    @(posedge clock);
    model_commit();
    @(negedge clock);
  endtask

  task automatic set_res(bit v, branch_t bt, cond_branch_t ct, logic [Width-1:0] pc,
                         logic [Width-1:0] a, logic [Width-1:0] b, logic [Width-1:0] tgt,
                         bit pt, logic [Width-1:0] ptgt);
    bus.res_valid        = v;
    bus.branch_type      = bt;
    bus.cond_branch_type = ct;
    bus.res_pc           = pc;
    bus.read_data_1      = a;
    bus.read_data_2      = b;
    bus.res_target       = tgt;
    bus.res_pred_taken   = pt;
    bus.res_pred_target  = ptgt;
  endtask

  task automatic idle();
    set_res(1'b0, NoBranch, Beq, '0, '0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [Width-1:0] rand_pc();
    return (64'($urandom_range(0, 1)) << 14) | (64'($urandom_range(0, 2)) << 6) |
           (64'($urandom_range(0, 3)) << 2)  | 64'($urandom_range(0, 3));
  endfunction

  function automatic logic [Width-1:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return {Width{1'b1}};
      3:       return 64'h8000_0000_0000_0000;
      default: return 64'd5;
    endcase
  endfunction

  task automatic test_reset();
    idle();
    bus.pred_pc = 64'h1000;
    rst_b = 1'b0;
    @(negedge clock);
    step();
    rst_b = 1'b1;
    #1;
    n_vec++; if (bus.pred_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b expected 0", bus.pred_hit); end
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b expected 0", bus.pred_taken); end
    n_vec++; if (bus.pred_target !== 64'h0) begin n_err++; $display("FAIL reset_target: got %h expected 0", bus.pred_target); end
    n_vec++; if (bus.branch_count !== 4'd0) begin n_err++; $display("FAIL reset_bc: got %0d expected 0", bus.branch_count); end
    n_vec++; if (bus.mispredict_count !== 4'd0) begin n_err++; $display("FAIL reset_mc: got %0d expected 0", bus.mispredict_count); end
    n_vec++; if (bus.pc_src !== PcPlus4) begin n_err++; $display("FAIL reset_pc_src: got %0d expected %0d", bus.pc_src, PcPlus4); end
  endtask

  task automatic test_cond_alloc();
    set_res(1'b1, CondBranch, Beq, 64'h1000, 64'd7, 64'd7, 64'h1040, 1'b0, 64'h0);
    #1;
    n_vec++; if (bus.pc_src !== PcOrReadDataPlusImm) begin n_err++; $display("FAIL beq_pc_src: got %0d expected %0d", bus.pc_src, PcOrReadDataPlusImm); end
    n_vec++; if (bus.mispredict !== 1'b1) begin n_err++; $display("FAIL beq_mispredict: got %b expected 1", bus.mispredict); end
    step();
    idle();
    bus.pred_pc = 64'h1000;
    #1;
    n_vec++; if (bus.pred_taken !== 1'b1) begin n_err++; $display("FAIL beq_pred_taken: got %b expected 1", bus.pred_taken); end
    n_vec++; if (bus.pred_target !== 64'h1040) begin n_err++; $display("FAIL beq_pred_target: got %h expected 1040", bus.pred_target); end
    n_vec++; if (bus.branch_count !== 4'd1) begin n_err++; $display("FAIL beq_bc: got %0d expected 1", bus.branch_count); end
    n_vec++; if (bus.mispredict_count !== 4'd1) begin n_err++; $display("FAIL beq_mc: got %0d expected 1", bus.mispredict_count); end
  endtask

  task automatic test_not_taken();
    bus.pred_pc = 64'h1000;
    set_res(1'b1, CondBranch, Beq, 64'h1000, 64'd1, 64'd2, 64'h1040, 1'b1, 64'h1040);
    #1;
    n_vec++; if (bus.mispredict !== 1'b1) begin n_err++; $display("FAIL nt1_mispredict: got %b expected 1", bus.mispredict); end
    n_vec++; if (bus.pc_src !== PcPlus4) begin n_err++; $display("FAIL nt1_pc_src: got %0d expected %0d", bus.pc_src, PcPlus4); end
    step();
    #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL nt1_pred_taken: got %b expected 0", bus.pred_taken); end
    bus.res_pred_taken = 1'b0;
    #1;
    n_vec++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL nt2_mispredict: got %b expected 0", bus.mispredict); end
    step();
    step();
    // counter sits at zero; one taken resolve must leave it below the taken threshold
    bus.read_data_2 = 64'd1;
    step();
    idle();
    #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL nt_saturate_low: got %b expected 0", bus.pred_taken); end
    n_vec++; if (bus.pred_hit !== 1'b1) begin n_err++; $display("FAIL nt_still_hit: got %b expected 1", bus.pred_hit); end
    set_res(1'b1, CondBranch, Bltu, 64'h1800, 64'd1, {Width{1'b1}}, 64'h1900, 1'b0, 64'h0);
    #1;
    n_vec++; if (bus.pc_src !== PcOrReadDataPlusImm) begin n_err++; $display("FAIL bltu_pc_src: got %0d expected %0d", bus.pc_src, PcOrReadDataPlusImm); end
    bus.cond_branch_type = Blt;
    #1;
    n_vec++; if (bus.pc_src !== PcPlus4) begin n_err++; $display("FAIL blt_pc_src: got %0d expected %0d", bus.pc_src, PcPlus4); end
    idle();
  endtask

  task automatic test_jump_retarget();
    set_res(1'b1, Jump, Beq, 64'h2000, '0, '0, 64'h3000, 1'b0, 64'h0);
    #1;
    n_vec++; if (bus.mispredict !== 1'b1) begin n_err++; $display("FAIL jmp1_mispredict: got %b expected 1", bus.mispredict); end
    step();
    idle();
    bus.pred_pc = 64'h2000;
    #1;
    n_vec++; if (bus.pred_target !== 64'h3000) begin n_err++; $display("FAIL jmp1_target: got %h expected 3000", bus.pred_target); end
    set_res(1'b1, Jump, Beq, 64'h2000, '0, '0, 64'h3100, 1'b1, 64'h3000);
    #1;
    n_vec++; if (bus.mispredict !== 1'b1) begin n_err++; $display("FAIL jmp2_mispredict: got %b expected 1", bus.mispredict); end
    n_vec++; if (bus.pred_target !== 64'h3000) begin n_err++; $display("FAIL jmp2_no_bypass: got %h expected 3000", bus.pred_target); end
    step();
    idle();
    #1;
    n_vec++; if (bus.pred_target !== 64'h3100) begin n_err++; $display("FAIL jmp2_target: got %h expected 3100", bus.pred_target); end
  endtask

  task automatic test_alias_and_trap();
    bus.pred_pc = 64'h6000;
    set_res(1'b1, NoBranch, Beq, 64'h6000, '0, '0, '0, 1'b1, 64'h3100);
    #1;
    n_vec++; if (bus.pred_hit !== 1'b1) begin n_err++; $display("FAIL alias_hit: got %b expected 1", bus.pred_hit); end
    n_vec++; if (bus.mispredict !== 1'b1) begin n_err++; $display("FAIL alias_mispredict: got %b expected 1", bus.mispredict); end
    n_vec++; if (bus.pc_src !== PcPlus4) begin n_err++; $display("FAIL alias_pc_src: got %0d expected %0d", bus.pc_src, PcPlus4); end
    step();
    idle();
    bus.pred_pc = 64'h2000;
    #1;
    n_vec++; if (bus.pred_hit !== 1'b0) begin n_err++; $display("FAIL alias_invalidate: got %b expected 0", bus.pred_hit); end
    set_res(1'b1, Jump, Beq, 64'h2000, '0, '0, 64'h3000, 1'b0, 64'h0);
    step();
    set_res(1'b1, Mret, Beq, 64'h2000, '0, '0, 64'h7700, 1'b0, 64'h0);
    #1;
    n_vec++; if (bus.pc_src !== Mepc) begin n_err++; $display("FAIL mret_pc_src: got %0d expected %0d", bus.pc_src, Mepc); end
    n_vec++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL mret_mispredict: got %b expected 0", bus.mispredict); end
    step();
    set_res(1'b1, Sret, Beq, 64'h2000, '0, '0, 64'h7700, 1'b1, 64'h0);
    #1;
    n_vec++; if (bus.pc_src !== Sepc) begin n_err++; $display("FAIL sret_pc_src: got %0d expected %0d", bus.pc_src, Sepc); end
    n_vec++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL sret_mispredict: got %b expected 0", bus.mispredict); end
    step();
    idle();
    #1;
    n_vec++; if (bus.pred_target !== 64'h3000) begin n_err++; $display("FAIL trap_no_change: got %h expected 3000", bus.pred_target); end
    n_vec++; if (bus.branch_count !== 4'(m_bc)) begin n_err++; $display("FAIL trap_bc: got %0d expected %0d", bus.branch_count, m_bc); end
  endtask

  task automatic test_count_saturate();
    for (int k = 0; k < 16; k++) begin
      set_res(1'b1, Jump, Beq, 64'h8000 + 64'(k * 4), '0, '0, 64'h9000, 1'b0, 64'h0);
      step();
    end
    idle();
    #1;
    n_vec++; if (bus.mispredict_count !== 4'd15) begin n_err++; $display("FAIL sat_mc: got %0d expected 15", bus.mispredict_count); end
    n_vec++; if (bus.branch_count !== 4'd15) begin n_err++; $display("FAIL sat_bc: got %0d expected 15", bus.branch_count); end
  endtask

  task automatic test_reset_midstream();
    set_res(1'b1, Jump, Beq, 64'h5000, '0, '0, 64'h5500, 1'b0, 64'h0);
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    idle();
    foreach (m_valid[k]) begin end
    for (int k = 0; k < 3; k++) begin
      bus.pred_pc = (k == 0) ? 64'h5000 : (k == 1) ? 64'h2000 : 64'h8004;
      #1;
      n_vec++; if (bus.pred_hit !== 1'b0) begin n_err++; $display("FAIL midreset_hit[%0d]: got %b expected 0", k, bus.pred_hit); end
    end
    n_vec++; if (bus.mispredict_count !== 4'd0) begin n_err++; $display("FAIL midreset_mc: got %0d expected 0", bus.mispredict_count); end
    n_vec++; if (bus.branch_count !== 4'd0) begin n_err++; $display("FAIL midreset_bc: got %0d expected 0", bus.branch_count); end
  endtask

  task automatic test_random();
    logic [Width-1:0] pc;
    for (int n = 0; n < 500; n++) begin
      rst_b = ($urandom_range(0, 59) != 0);
      pc = rand_pc();
      set_res($urandom_range(0, 5) != 0, branch_t'($urandom_range(0, 4)),
              cond_branch_t'($urandom_range(0, 5)), pc, rand_op(), rand_op(),
              64'h4000 + 64'($urandom_range(0, 3) * 16), 1'b0, 64'h0);
      if ($urandom_range(0, 1) == 1) begin
        bus.res_pred_taken  = m_taken(pc);
        bus.res_pred_target = m_tgt(pc);
      end else begin
        bus.res_pred_taken  = 1'($urandom_range(0, 1));
        bus.res_pred_target = 64'h4000 + 64'($urandom_range(0, 3) * 16);
      end
      bus.pred_pc = ($urandom_range(0, 2) == 0) ? pc : rand_pc();
      #1;
      n_vec++; if (bus.pred_hit !== m_hit(bus.pred_pc)) begin n_err++; $display("FAIL rnd_hit[%0d]: got %b expected %b", n, bus.pred_hit, m_hit(bus.pred_pc)); end
      n_vec++; if (bus.pred_taken !== m_taken(bus.pred_pc)) begin n_err++; $display("FAIL rnd_taken[%0d]: got %b expected %b", n, bus.pred_taken, m_taken(bus.pred_pc)); end
      n_vec++; if (bus.pred_target !== m_tgt(bus.pred_pc)) begin n_err++; $display("FAIL rnd_target[%0d]: got %h expected %h", n, bus.pred_target, m_tgt(bus.pred_pc)); end
      n_vec++; if (bus.pc_src !== m_pc_src()) begin n_err++; $display("FAIL rnd_pc_src[%0d]: got %0d expected %0d", n, bus.pc_src, m_pc_src()); end
      n_vec++; if (bus.mispredict !== m_mis()) begin n_err++; $display("FAIL rnd_mispredict[%0d]: got %b expected %b", n, bus.mispredict, m_mis()); end
      n_vec++; if (bus.branch_count !== 4'(m_bc)) begin n_err++; $display("FAIL rnd_bc[%0d]: got %0d expected %0d", n, bus.branch_count, m_bc); end
      n_vec++; if (bus.mispredict_count !== 4'(m_mc)) begin n_err++; $display("FAIL rnd_mc[%0d]: got %0d expected %0d", n, bus.mispredict_count, m_mc); end
      step();
    end
    rst_b = 1'b1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    m_bc  = 0;
    m_mc  = 0;
    idle();
    bus.pred_pc = '0;
    test_reset();
    test_cond_alloc();
    test_not_taken();
    test_jump_retarget();
    test_alias_and_trap();
    test_count_saturate();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor_unit.md
# branch_predictor_unit

Parametrised successor to `branch_decoder_unit` that adds dynamic prediction. It keeps a direct-mapped branch target buffer (BTB) of saturating direction counters. Fetch reads a taken/target prediction for the current PC in the same cycle. Execute resolves the branch with the same `branch_t`/`cond_branch_t` semantics as the decoder, drives the architecturally correct `pc_src`, flags mispredictions, trains the table and keeps performance counters.

## Interface
- `Width`, 64: data and PC width.
- `Entries`, 64: number of BTB entries; a power of two, at least 2.
- `TagBits`, 8: stored tag width.
- `CounterBits`, 2: direction counter width, at least 1.
- `CountBits`, 32: width of each performance counter.
- `clock` in 1: single clock for everything.
- `reset` in 1: synchronous, active-low. Sampled 0 on a rising `clock` edge resets the block.
- `pred_pc` in Width: fetch PC.
- `pred_hit` out 1: the indexed entry is valid and its tag matches.
- `pred_taken` out 1: `pred_hit` AND counter MSB = 1.
- `pred_target` out Width: stored target when `pred_taken`, else 0.
- `res_valid` in 1: a resolve request is present this cycle.
- `res_pc` in Width: PC of the resolving instruction.
- `branch_type` in `branch_t`: NoBranch, Jump, CondBranch, Mret or Sret.
- `cond_branch_type` in `cond_branch_t`: Beq, Bne, Blt, Bge, Bltu or Bgeu.
- `read_data_1`, `read_data_2` in Width each: operands.
- `res_target` in Width: computed PC+imm or reg+imm target.
- `res_pred_taken` in 1, `res_pred_target` in Width: the prediction made for this instruction, carried down the pipeline.
- `pc_src` out `pc_src_t`: correct next-PC source.
- `mispredict` out 1: fetch must redirect using `pc_src`.
- `branch_count`, `mispredict_count` out CountBits each: performance counters.

## Operation
- Index is `pc[IndexBits+1:2]`, where IndexBits = log2(Entries).
- Tag is `pc[IndexBits+TagBits+1:IndexBits+2]`.
- Each entry holds a valid bit, a tag, a Width-bit target and a CounterBits-wide counter.
- Actual outcome when `res_valid` = 1:
  - NoBranch: not taken.
  - Jump: taken.
  - CondBranch: Beq/Bne use equality. Blt/Bge use signed compare. Bltu/Bgeu use unsigned compare, all over the full Width.
  - Mret/Sret: redirect with no prediction.
- `pc_src` is combinational from the current inputs:
  - Mret gives Mepc; Sret gives Sepc.
  - Taken gives PcOrReadDataPlusImm.
  - Otherwise, including `res_valid` = 0, it gives PcPlus4.
- `mispredict` = `res_valid` AND NOT Mret/Sret AND (actual ≠ `res_pred_taken` OR (actual AND `res_target` ≠ `res_pred_target`)).
  - Mret/Sret never assert `mispredict`; the trap path handles them.
- Training happens on the rising edge when `res_valid` = 1 and `reset` = 1.
  - Hit on Jump or CondBranch: counter +1 if taken, −1 if not, saturating at all-ones and zero. If taken, target is overwritten with `res_target`.
  - Miss on taken Jump: allocate (valid=1, tag, target, counter = all-ones), overwriting any previous occupant.
  - Miss on taken CondBranch: allocate with counter = weakly taken (MSB=1, rest 0).
  - Miss on not-taken CondBranch: no allocation.
  - NoBranch that hits (aliasing): clear that entry's valid bit.
  - Mret/Sret: no table access.
- Counters, evaluated on the same edge:
  - `branch_count` +1 per `res_valid` Jump or CondBranch.
  - `mispredict_count` +1 per `mispredict`.
  - Both saturate at all-ones and never wrap.

## Timing
- Prediction is a combinational read of table flops: 0-cycle latency from `pred_pc`.
- `pc_src` and `mispredict` are combinational in the resolve cycle.
- Table and counter updates become visible the cycle after the resolve edge.
- Same-cycle predict and resolve on the same index: the prediction reflects pre-update contents. There is no bypass.
- Reset (edge with `reset` = 0):
  - All valid bits clear.
  - Every counter goes to weakly not-taken (MSB=0, rest all-ones).
  - Both performance counters go to 0.
  - Targets and tags are don't-care.
  - The resolve request in that cycle is discarded.
  - After reset: `pred_hit` = 0, `pred_taken` = 0, `pred_target` = 0 for every PC.
- Reset mid-stream: table state is lost on that edge. Outputs obey the above from the next cycle.

## Test plan
- Reset, then `pred_pc` = 0x1000 → `pred_hit` = 0, `pred_target` = 0, both counters 0.
- Resolve CondBranch Beq at 0x1000 with equal operands and target 0x1040, `res_pred_taken` = 0 → `pc_src` = PcOrReadDataPlusImm, `mispredict` = 1.
  - Next cycle `pred_pc` = 0x1000 → `pred_taken` = 1, `pred_target` = 0x1040.
  - `branch_count` = 1, `mispredict_count` = 1.
- The same branch resolved not-taken twice → `pred_taken` drops to 0 after the first; the counter saturates at 0 after the second. Bltu with 1 vs −1 is taken; Blt with the same operands is not taken.
- Jump at 0x2000 to 0x3000, then Jump at 0x2000 to 0x3100 with correct prediction bit → second resolve asserts `mispredict` (target differs), and the entry's target becomes 0x3100.
- NoBranch resolved at an aliasing PC that hits, with `res_pred_taken` = 1 → `mispredict` = 1, `pc_src` = PcPlus4, and the entry is invalidated. Mret → `pc_src` = Mepc, `mispredict` = 0, no table change.
- With CountBits = 4: 16 mispredicts → `mispredict_count` holds 15. Assert `reset` mid-sequence → all predictions miss the next cycle.
